// File: rtl/pulse_to_level_converter.sv
// Turns single-cycle event pulses into fixed-length level windows separated by a minimum gap.
// Optional PTL_RETRIGGER_EN: events during a window extend it instead of being queued.
module pulse_to_level_converter #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_DEPTH  = 3,
   parameter int PEND_W      = $clog2(PEND_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pulse_in,
   input  logic              ovf_clr,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending_cnt,
   output logic              overflow
);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_DEPTH);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [PEND_W-1:0]   pend_nxt;
   logic                drop;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pending_cnt;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (pulse_in) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
            if (pulse_in) begin
`ifdef PTL_RETRIGGER_EN
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
`else
               // An event on the last hold cycle is queued, never merged into this window.
               if (pending_cnt < PEND_FULL) pend_nxt = pending_cnt + 1'b1;
               else                         drop     = 1'b1;
`endif
            end
         end
         GAP: begin
            if (cnt == '0) begin
               if (pulse_in || (pending_cnt != '0)) begin
                  state_nxt = HOLD;
                  cnt_nxt   = HOLD_LOAD;
                  // With an event present, dequeue and enqueue cancel out.
                  if (!pulse_in) pend_nxt = pending_cnt - 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
               if (pulse_in) begin
                  if (pending_cnt < PEND_FULL) pend_nxt = pending_cnt + 1'b1;
                  else                         drop     = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pend_nxt  = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         pending_cnt <= '0;
         overflow    <= 1'b0;
         level_out   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         pending_cnt <= pend_nxt;
         overflow    <= drop | (overflow & ~ovf_clr);
         level_out   <= (state_nxt == HOLD);
         busy        <= (state_nxt != IDLE);
      end
   end

endmodule
